// File: rtl/fetch_predecode_queue.sv
// ---------------------------------------------------------------------------
// fetch_predecode_queue
//
// Purpose:
//   Sits behind the fetch stage. It pre-decodes the 40-bit little-endian
//   window fetched at the current PC and hands fetch its next-PC controls in
//   the same cycle: enable, length, jump flag/target and halt. Each accepted
//   instruction is buffered in a small circular FIFO and offered to decode
//   over a valid/ready handshake. This block owns fetch back-pressure and the
//   sticky halted state.
//
// Ports:
//   clk_i, rst_ni        rising-edge clock, asynchronous active-low reset
//   fetch_pc_i           PC of the current fetch window
//   fetch_instr_i        window bytes, [7:0] is the byte at fetch_pc_i
//   pc_we_o              fetch advances and the window is enqueued this edge
//   instr_length_o       decoded length in bytes (1..5)
//   is_jmp_o             window is an unconditional relative jump
//   jmp_target_o         sign-extended displacement (fetch adds PC+len+target)
//   is_halt_o            window is HLT or the block is already halted
//   dq_valid_o/ready_i   decode handshake for the head entry
//   dq_pc_o, dq_opcode_o, dq_imm_o, dq_length_o, dq_illegal_o
//                        fields of the head entry, zero while the queue is empty
//   halted_o             sticky halt flag, cleared only by reset
//   occupancy_o          number of valid entries (0..DEPTH)
// ---------------------------------------------------------------------------
module fetch_predecode_queue #(
    parameter int DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] fetch_pc_i,
    input  logic [39:0] fetch_instr_i,
    output logic        pc_we_o,
    output logic [2:0]  instr_length_o,
    output logic        is_jmp_o,
    output logic [31:0] jmp_target_o,
    output logic        is_halt_o,
    output logic        dq_valid_o,
    input  logic        dq_ready_i,
    output logic [31:0] dq_pc_o,
    output logic [7:0]  dq_opcode_o,
    output logic [31:0] dq_imm_o,
    output logic [2:0]  dq_length_o,
    output logic        dq_illegal_o,
    output logic        halted_o,
    output logic [2:0]  occupancy_o
);

    // DEPTH is restricted to powers of two, so pointers wrap naturally.
    localparam int         PTR_W   = $clog2(DEPTH);
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    typedef enum logic {
        RUN,
        HALTED
    } haltState_e;

    haltState_e state_q, state_d;

    logic [7:0]  opcode;
    logic [2:0]  decLength;
    logic [31:0] decImm;
    logic        decIllegal;
    logic        decJmp;
    logic        isHalted;
    logic        doEnq;
    logic        doDeq;
    logic        headValid;

    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [2:0]       count_q, count_d;

    logic [31:0] pcMem_q     [DEPTH];
    logic [7:0]  opcodeMem_q [DEPTH];
    logic [31:0] immMem_q    [DEPTH];
    logic [2:0]  lengthMem_q [DEPTH];
    logic        illegalMem_q[DEPTH];

    // Pre-decode of the current window. Unknown opcodes are treated as
    // single-byte so fetch still makes forward progress past them.
    always_comb begin
        opcode     = fetch_instr_i[7:0];
        decLength  = 3'd1;
        decImm     = 32'd0;
        decIllegal = 1'b0;
        decJmp     = 1'b0;
        case (opcode)
            8'h90, 8'hF4,
            8'h40, 8'h41, 8'h42, 8'h43,
            8'h44, 8'h45, 8'h46, 8'h47: decLength = 3'd1;
            8'h04: begin
                decLength = 3'd2;
                decImm    = {{24{fetch_instr_i[15]}}, fetch_instr_i[15:8]};
            end
            8'hEB: begin
                decLength = 3'd2;
                decImm    = {{24{fetch_instr_i[15]}}, fetch_instr_i[15:8]};
                decJmp    = 1'b1;
            end
            8'h05: begin
                decLength = 3'd5;
                decImm    = fetch_instr_i[39:8];
            end
            8'hE9: begin
                decLength = 3'd5;
                decImm    = fetch_instr_i[39:8];
                decJmp    = 1'b1;
            end
            default: decIllegal = 1'b1;
        endcase
    end

    // Halt state register. Reset is the only way back to RUN.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Halt next state: HLT only takes effect on the edge that enqueues it,
    // so an HLT blocked by a full queue is simply re-decoded later.
    always_comb begin
        state_d = state_q;
        if (state_q == RUN && doEnq && opcode == 8'hF4) begin
            state_d = HALTED;
        end
    end

    // Halt outputs.
    always_comb begin
        isHalted = (state_q == HALTED);
    end

    // Fetch-side controls. rst_ni is folded in so fetch is frozen while reset
    // is held, and is free again as soon as reset releases.
    always_comb begin
        headValid      = (count_q != 3'd0);
        pc_we_o        = rst_ni && !isHalted && (count_q < DEPTH_C);
        doEnq          = pc_we_o;
        doDeq          = headValid && dq_ready_i;
        instr_length_o = decLength;
        is_jmp_o       = decJmp;
        jmp_target_o   = decJmp ? decImm : 32'd0;
        is_halt_o      = isHalted || (opcode == 8'hF4);
        halted_o       = isHalted;
        occupancy_o    = count_q;
    end

    // Pointer and occupancy next state; simultaneous enqueue and dequeue
    // leave the count where it is.
    always_comb begin
        wrPtr_d = doEnq ? wrPtr_q + PTR_W'(1) : wrPtr_q;
        rdPtr_d = doDeq ? rdPtr_q + PTR_W'(1) : rdPtr_q;
        case ({doEnq, doDeq})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= 3'd0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Entry storage. Contents need no reset because the head is masked
    // whenever the queue is empty.
    always_ff @(posedge clk_i) begin
        if (doEnq) begin
            pcMem_q[wrPtr_q]      <= fetch_pc_i;
            opcodeMem_q[wrPtr_q]  <= opcode;
            immMem_q[wrPtr_q]     <= decImm;
            lengthMem_q[wrPtr_q]  <= decLength;
            illegalMem_q[wrPtr_q] <= decIllegal;
        end
    end

    // Head presentation to decode, forced to zero when nothing is valid.
    always_comb begin
        dq_valid_o   = headValid;
        dq_pc_o      = headValid ? pcMem_q[rdPtr_q]      : 32'd0;
        dq_opcode_o  = headValid ? opcodeMem_q[rdPtr_q]  : 8'd0;
        dq_imm_o     = headValid ? immMem_q[rdPtr_q]     : 32'd0;
        dq_length_o  = headValid ? lengthMem_q[rdPtr_q]  : 3'd0;
        dq_illegal_o = headValid ? illegalMem_q[rdPtr_q] : 1'b0;
    end

endmodule

// File: tb/tb_fetch_predecode_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_predecode_queue
//
// Directed bench for fetch_predecode_queue with DEPTH=2. Inputs change on
// the falling edge; outputs are sampled on the falling edge or shortly after
// it, well away from the rising edge the DUT uses.
// ---------------------------------------------------------------------------
module tb_fetch_predecode_queue;

    logic        clk;
    logic        rstN;
    logic [31:0] fetchPc;
    logic [39:0] fetchInstr;
    logic        pcWe;
    logic [2:0]  instrLength;
    logic        isJmp;
    logic [31:0] jmpTarget;
    logic        isHalt;
    logic        dqValid;
    logic        dqReady;
    logic [31:0] dqPc;
    logic [7:0]  dqOpcode;
    logic [31:0] dqImm;
    logic [2:0]  dqLength;
    logic        dqIllegal;
    logic        halted;
    logic [2:0]  occupancy;

    int checks = 0;
    int errors = 0;

    fetch_predecode_queue #(.DEPTH(2)) dut (
        .clk_i          (clk),
        .rst_ni         (rstN),
        .fetch_pc_i     (fetchPc),
        .fetch_instr_i  (fetchInstr),
        .pc_we_o        (pcWe),
        .instr_length_o (instrLength),
        .is_jmp_o       (isJmp),
        .jmp_target_o   (jmpTarget),
        .is_halt_o      (isHalt),
        .dq_valid_o     (dqValid),
        .dq_ready_i     (dqReady),
        .dq_pc_o        (dqPc),
        .dq_opcode_o    (dqOpcode),
        .dq_imm_o       (dqImm),
        .dq_length_o    (dqLength),
        .dq_illegal_o   (dqIllegal),
        .halted_o       (halted),
        .occupancy_o    (occupancy)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive the fetch window and the decode ready line.
    task automatic applyStimulus(input logic [31:0] pc, input logic [39:0] instr,
                                 input logic ready);
        fetchPc    = pc;
        fetchInstr = instr;
        dqReady    = ready;
    endtask

    // One comparison: counts it and reports a failure with both values.
    task automatic checkOutput(input string tag, input logic [39:0] observed,
                               input logic [39:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance through one rising edge and land on the following falling edge.
    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Directed sequence.
    initial begin
        rstN = 1'b0;
        applyStimulus(32'd0, 40'h90, 1'b0);
        repeat (2) @(negedge clk);

        checkOutput("rst_occupancy", 40'(occupancy), 40'd0);
        checkOutput("rst_dq_valid", 40'(dqValid), 40'd0);
        checkOutput("rst_halted", 40'(halted), 40'd0);
        checkOutput("rst_pc_we", 40'(pcWe), 40'd0);
        checkOutput("rst_dq_pc", 40'(dqPc), 40'd0);
        checkOutput("rst_dq_opcode", 40'(dqOpcode), 40'd0);

        // Release reset; illegal opcode 0x00 decodes as length 1.
        rstN = 1'b1;
        applyStimulus(32'd0, 40'h0403020100, 1'b1);
        #1;
        checkOutput("ill_len", 40'(instrLength), 40'd1);
        checkOutput("ill_pc_we", 40'(pcWe), 40'd1);
        checkOutput("ill_is_jmp", 40'(isJmp), 40'd0);
        checkOutput("ill_is_halt", 40'(isHalt), 40'd0);
        checkOutput("empty_dq_valid", 40'(dqValid), 40'd0);
        stepCycle();
        checkOutput("ill_dq_valid", 40'(dqValid), 40'd1);
        checkOutput("ill_dq_pc", 40'(dqPc), 40'd0);
        checkOutput("ill_dq_opcode", 40'(dqOpcode), 40'd0);
        checkOutput("ill_dq_illegal", 40'(dqIllegal), 40'd1);
        checkOutput("ill_dq_length", 40'(dqLength), 40'd1);
        checkOutput("ill_dq_imm", 40'(dqImm), 40'd0);
        checkOutput("ill_occupancy", 40'(occupancy), 40'd1);

        // JMP rel32 +20 at PC 10: next PC 35; dequeue and enqueue together.
        applyStimulus(32'd10, 40'h00000014E9, 1'b1);
        #1;
        checkOutput("j32_is_jmp", 40'(isJmp), 40'd1);
        checkOutput("j32_len", 40'(instrLength), 40'd5);
        checkOutput("j32_target", 40'(jmpTarget), 40'd20);
        checkOutput("j32_next_pc", 40'(fetchPc + 32'(instrLength) + jmpTarget), 40'd35);
        checkOutput("j32_pc_we", 40'(pcWe), 40'd1);
        stepCycle();
        checkOutput("j32_occupancy", 40'(occupancy), 40'd1);
        checkOutput("j32_dq_pc", 40'(dqPc), 40'd10);
        checkOutput("j32_dq_opcode", 40'(dqOpcode), 40'hE9);
        checkOutput("j32_dq_imm", 40'(dqImm), 40'd20);
        checkOutput("j32_dq_length", 40'(dqLength), 40'd5);
        checkOutput("j32_dq_illegal", 40'(dqIllegal), 40'd0);

        // JMP rel8 -2; decode stalls so the queue fills.
        applyStimulus(32'd35, 40'h000000FEEB, 1'b0);
        #1;
        checkOutput("j8_target", 40'(jmpTarget), 40'hFFFFFFFE);
        checkOutput("j8_len", 40'(instrLength), 40'd2);
        checkOutput("j8_is_jmp", 40'(isJmp), 40'd1);
        stepCycle();
        checkOutput("full_occupancy", 40'(occupancy), 40'd2);
        checkOutput("full_pc_we", 40'(pcWe), 40'd0);
        checkOutput("full_dq_pc_stable", 40'(dqPc), 40'd10);

        // Full and stalled: nothing moves.
        applyStimulus(32'd35, 40'h90, 1'b0);
        #1;
        checkOutput("nop_len", 40'(instrLength), 40'd1);
        checkOutput("hold_pc_we", 40'(pcWe), 40'd0);
        stepCycle();
        checkOutput("hold_occupancy", 40'(occupancy), 40'd2);
        checkOutput("hold_dq_pc", 40'(dqPc), 40'd10);

        // One-cycle ready pulse frees a slot.
        applyStimulus(32'd35, 40'h90, 1'b1);
        stepCycle();
        checkOutput("pulse_occupancy", 40'(occupancy), 40'd1);
        checkOutput("pulse_pc_we", 40'(pcWe), 40'd1);
        checkOutput("pulse_dq_pc", 40'(dqPc), 40'd35);
        checkOutput("pulse_dq_opcode", 40'(dqOpcode), 40'hEB);
        checkOutput("pulse_dq_imm", 40'(dqImm), 40'hFFFFFFFE);
        checkOutput("pulse_dq_length", 40'(dqLength), 40'd2);

        // ADD EAX,imm32 is not a jump; refills the queue.
        applyStimulus(32'd37, 40'h1234567805, 1'b0);
        #1;
        checkOutput("add32_len", 40'(instrLength), 40'd5);
        checkOutput("add32_is_jmp", 40'(isJmp), 40'd0);
        checkOutput("add32_target", 40'(jmpTarget), 40'd0);
        stepCycle();
        checkOutput("add32_occupancy", 40'(occupancy), 40'd2);

        // HLT while full is not enqueued and does not halt.
        applyStimulus(32'd42, 40'hF4, 1'b0);
        #1;
        checkOutput("hltfull_is_halt", 40'(isHalt), 40'd1);
        checkOutput("hltfull_pc_we", 40'(pcWe), 40'd0);
        stepCycle();
        checkOutput("hltfull_halted", 40'(halted), 40'd0);
        checkOutput("hltfull_occupancy", 40'(occupancy), 40'd2);

        applyStimulus(32'd42, 40'hF4, 1'b1);
        stepCycle();
        checkOutput("drain_occupancy", 40'(occupancy), 40'd1);
        checkOutput("drain_halted", 40'(halted), 40'd0);
        checkOutput("drain_dq_pc", 40'(dqPc), 40'd37);
        checkOutput("drain_dq_opcode", 40'(dqOpcode), 40'h05);
        checkOutput("drain_dq_imm", 40'(dqImm), 40'h12345678);

        // HLT now has room: enqueued, then halted.
        applyStimulus(32'd42, 40'hF4, 1'b0);
        #1;
        checkOutput("hlt_pc_we", 40'(pcWe), 40'd1);
        checkOutput("hlt_is_halt", 40'(isHalt), 40'd1);
        stepCycle();
        checkOutput("hlt_halted", 40'(halted), 40'd1);
        checkOutput("hlt_occupancy", 40'(occupancy), 40'd2);
        checkOutput("hlt_pc_we_after", 40'(pcWe), 40'd0);

        // ADD AL,imm8 while halted: is_halt comes from the sticky flag.
        applyStimulus(32'd43, 40'h8004, 1'b0);
        #1;
        checkOutput("halted_is_halt", 40'(isHalt), 40'd1);
        checkOutput("add8_len", 40'(instrLength), 40'd2);
        checkOutput("add8_target", 40'(jmpTarget), 40'd0);
        checkOutput("halted_pc_we", 40'(pcWe), 40'd0);

        // Asynchronous reset with the queue full and halted.
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("async_occupancy", 40'(occupancy), 40'd0);
        checkOutput("async_dq_valid", 40'(dqValid), 40'd0);
        checkOutput("async_halted", 40'(halted), 40'd0);
        checkOutput("async_pc_we", 40'(pcWe), 40'd0);
        checkOutput("async_dq_opcode", 40'(dqOpcode), 40'd0);
        @(negedge clk);
        rstN = 1'b1;

        // INC then HLT, then drain to decode while halted.
        applyStimulus(32'd100, 40'h41, 1'b0);
        #1;
        checkOutput("inc_len", 40'(instrLength), 40'd1);
        checkOutput("inc_pc_we", 40'(pcWe), 40'd1);
        stepCycle();
        checkOutput("inc_occupancy", 40'(occupancy), 40'd1);
        checkOutput("inc_dq_pc", 40'(dqPc), 40'd100);
        checkOutput("inc_dq_opcode", 40'(dqOpcode), 40'h41);
        checkOutput("inc_dq_illegal", 40'(dqIllegal), 40'd0);

        applyStimulus(32'd101, 40'hF4, 1'b0);
        stepCycle();
        checkOutput("hlt2_occupancy", 40'(occupancy), 40'd2);
        checkOutput("hlt2_halted", 40'(halted), 40'd1);

        applyStimulus(32'd102, 40'h90, 1'b1);
        stepCycle();
        checkOutput("hdrain1_occupancy", 40'(occupancy), 40'd1);
        checkOutput("hdrain1_dq_pc", 40'(dqPc), 40'd101);
        checkOutput("hdrain1_dq_opcode", 40'(dqOpcode), 40'hF4);
        checkOutput("hdrain1_pc_we", 40'(pcWe), 40'd0);
        checkOutput("hdrain1_halted", 40'(halted), 40'd1);
        stepCycle();
        checkOutput("hdrain2_occupancy", 40'(occupancy), 40'd0);
        checkOutput("hdrain2_dq_valid", 40'(dqValid), 40'd0);
        stepCycle();
        checkOutput("hdrain3_occupancy", 40'(occupancy), 40'd0);
        checkOutput("hdrain3_dq_valid", 40'(dqValid), 40'd0);
        checkOutput("hdrain3_pc_we", 40'(pcWe), 40'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
